// File: rtl/lagarto_pmu_counters.sv
// PMU event-counter bank: registered event inputs, per-event 64-bit counters,
// sticky overflow status with interrupt, and a single-cycle register port.
module lagarto_pmu_counters #(
  parameter int unsigned NUM_EVENTS = 23,
  parameter int unsigned CNT_WIDTH  = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NUM_EVENTS-1:0] pmu_sig_i,
  input  logic                  req_valid_i,
  input  logic                  req_we_i,
  input  logic [7:0]            req_addr_i,
  input  logic [63:0]           req_wdata_i,
  output logic                  resp_valid_o,
  output logic [63:0]           resp_rdata_o,
  output logic                  resp_err_o,
  output logic                  ovf_irq_o
);

  localparam logic [7:0] A_CTRL       = 8'h00;
  localparam logic [7:0] A_EN_MASK    = 8'h01;
  localparam logic [7:0] A_OVF_STATUS = 8'h02;
  localparam logic [7:0] A_OVF_CLEAR  = 8'h03;
  localparam logic [7:0] A_OVF_IRQ_EN = 8'h04;
  localparam int unsigned CNT_BASE    = 32;

  logic [NUM_EVENTS-1:0] r_evt_q;
  logic [NUM_EVENTS-1:0] r_en_mask;
  logic [NUM_EVENTS-1:0] r_ovf_status;
  logic [NUM_EVENTS-1:0] r_ovf_irq_en;
  logic                  r_enable;
  logic                  r_freeze;
  logic [CNT_WIDTH-1:0]  r_cnt [NUM_EVENTS];
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [63:0]           r_resp_rdata;
  logic                  r_ovf_irq;

  logic                  w_wr;
  logic                  w_sel_ctrl;
  logic                  w_sel_en_mask;
  logic                  w_sel_ovf_status;
  logic                  w_sel_ovf_clear;
  logic                  w_sel_ovf_irq_en;
  logic [NUM_EVENTS-1:0] w_cnt_hit;
  logic                  w_hit;
  logic                  w_clear_all;
  logic [NUM_EVENTS-1:0] w_cnt_wr;
  logic [NUM_EVENTS-1:0] w_inc;
  logic [NUM_EVENTS-1:0] w_ovf_set;
  logic [NUM_EVENTS-1:0] w_ovf_clr;
  logic [NUM_EVENTS-1:0] w_ovf_next;
  logic [63:0]           w_rdata;

  assign w_wr             = req_valid_i & req_we_i;
  assign w_sel_ctrl       = (req_addr_i == A_CTRL);
  assign w_sel_en_mask    = (req_addr_i == A_EN_MASK);
  assign w_sel_ovf_status = (req_addr_i == A_OVF_STATUS);
  assign w_sel_ovf_clear  = (req_addr_i == A_OVF_CLEAR);
  assign w_sel_ovf_irq_en = (req_addr_i == A_OVF_IRQ_EN);
  assign w_hit            = w_sel_ctrl | w_sel_en_mask | w_sel_ovf_status |
                            w_sel_ovf_clear | w_sel_ovf_irq_en | (|w_cnt_hit);
  assign w_clear_all      = w_wr & w_sel_ctrl & req_wdata_i[2];
  assign w_ovf_clr        = (w_wr & w_sel_ovf_clear) ? req_wdata_i[NUM_EVENTS-1:0] : '0;

  // A wrap only counts when the increment actually wins over a direct write.
  always_comb begin
    w_cnt_hit = '0;
    w_cnt_wr  = '0;
    w_inc     = '0;
    w_ovf_set = '0;
    for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
      w_cnt_hit[i] = (req_addr_i == 8'(CNT_BASE + i));
      w_cnt_wr[i]  = w_wr & w_cnt_hit[i];
      w_inc[i]     = r_evt_q[i] & r_en_mask[i] & r_enable & ~r_freeze;
      w_ovf_set[i] = w_inc[i] & (&r_cnt[i]) & ~w_cnt_wr[i];
    end
  end

  assign w_ovf_next = w_clear_all ? '0 : ((r_ovf_status & ~w_ovf_clr) | w_ovf_set);

  always_comb begin
    w_rdata = '0;
    if (w_sel_ctrl) begin
      w_rdata[0] = r_enable;
      w_rdata[1] = r_freeze;
    end else if (w_sel_en_mask) begin
      w_rdata[NUM_EVENTS-1:0] = r_en_mask;
    end else if (w_sel_ovf_status) begin
      w_rdata[NUM_EVENTS-1:0] = r_ovf_status;
    end else if (w_sel_ovf_irq_en) begin
      w_rdata[NUM_EVENTS-1:0] = r_ovf_irq_en;
    end else begin
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        if (w_cnt_hit[i]) w_rdata[CNT_WIDTH-1:0] = r_cnt[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_evt_q      <= '0;
      r_en_mask    <= '0;
      r_ovf_status <= '0;
      r_ovf_irq_en <= '0;
      r_enable     <= 1'b0;
      r_freeze     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_ovf_irq    <= 1'b0;
      for (int unsigned i = 0; i < NUM_EVENTS; i++) r_cnt[i] <= '0;
    end else begin
      r_evt_q      <= pmu_sig_i;
      r_resp_valid <= req_valid_i;
      r_resp_err   <= req_valid_i & ~w_hit;
      r_resp_rdata <= (req_valid_i & ~req_we_i & w_hit) ? w_rdata : '0;
      if (w_wr & w_sel_ctrl) begin
        r_enable <= req_wdata_i[0];
        r_freeze <= req_wdata_i[1];
      end
      if (w_wr & w_sel_en_mask)    r_en_mask    <= req_wdata_i[NUM_EVENTS-1:0];
      if (w_wr & w_sel_ovf_irq_en) r_ovf_irq_en <= req_wdata_i[NUM_EVENTS-1:0];
      r_ovf_status <= w_ovf_next;
      r_ovf_irq    <= |(r_ovf_status & r_ovf_irq_en);
      for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
        if (w_clear_all)      r_cnt[i] <= '0;
        else if (w_cnt_wr[i]) r_cnt[i] <= req_wdata_i[CNT_WIDTH-1:0];
        else if (w_inc[i])    r_cnt[i] <= r_cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = r_resp_rdata;
  assign resp_err_o   = r_resp_err;
  assign ovf_irq_o    = r_ovf_irq;

endmodule

// File: tb/tb_lagarto_pmu_counters.sv
// Scoreboard bench for lagarto_pmu_counters: requests push expected responses,
// a negedge monitor pops and compares them along with queued direct checks.
module tb_lagarto_pmu_counters;

  localparam int unsigned NE = 23;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [NE-1:0] pmu_sig_i;
  logic          req_valid_i;
  logic          req_we_i;
  logic [7:0]    req_addr_i;
  logic [63:0]   req_wdata_i;
  logic          resp_valid_o;
  logic [63:0]   resp_rdata_o;
  logic          resp_err_o;
  logic          ovf_irq_o;

  lagarto_pmu_counters #(.NUM_EVENTS(NE), .CNT_WIDTH(64)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pmu_sig_i(pmu_sig_i),
    .req_valid_i(req_valid_i), .req_we_i(req_we_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .resp_valid_o(resp_valid_o),
    .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .ovf_irq_o(ovf_irq_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    logic [7:0]  addr;
  } resp_t;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  resp_t resp_q[$];
  chk_t  chk_q[$];
  int    total = 0;
  int    bad   = 0;
  bit    tb_end = 1'b0;
  bit    mon_done = 1'b0;

  initial begin : monitor
    resp_t r;
    chk_t  c;
    forever begin
      @(negedge clk_i);
      if (resp_valid_o) begin
        total++;
        if (resp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_resp got rdata=%h err=%b want no response", resp_rdata_o, resp_err_o);
        end else begin
          r = resp_q.pop_front();
          if (resp_rdata_o !== r.rdata || resp_err_o !== r.err) begin
            bad++;
            $display("FAIL resp_addr_%h got rdata=%h err=%b want rdata=%h err=%b",
                     r.addr, resp_rdata_o, resp_err_o, r.rdata, r.err);
          end
        end
      end
      while (chk_q.size() > 0) begin
        c = chk_q.pop_front();
        total++;
        if (c.act !== c.exp) begin
          bad++;
          $display("FAIL %s got=%h want=%h", c.name, c.act, c.exp);
        end
      end
      if (tb_end && !mon_done) begin
        total++;
        if (resp_q.size() != 0) begin
          bad++;
          $display("FAIL missing_resp got pending=%0d want pending=0", resp_q.size());
        end
        mon_done = 1'b1;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_q.push_back('{name, act, exp});
  endtask

  task automatic req(input logic we, input logic [7:0] a, input logic [63:0] wd,
                     input logic [63:0] er, input logic ee);
    req_valid_i = 1'b1;
    req_we_i    = we;
    req_addr_i  = a;
    req_wdata_i = wd;
    resp_q.push_back('{er, ee, a});
    @(posedge clk_i); #1;
    req_valid_i = 1'b0;
    req_we_i    = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [63:0] d);
    req(1'b1, a, d, 64'd0, 1'b0);
  endtask

  task automatic rd(input logic [7:0] a, input logic [63:0] e);
    req(1'b0, a, 64'd0, e, 1'b0);
  endtask

  // Drives the mask for n cycles, then waits one more cycle so the last
  // registered event has been counted before the caller reads.
  task automatic pulse(input logic [NE-1:0] m, input int n);
    pmu_sig_i = m;
    repeat (n) @(posedge clk_i);
    #1;
    pmu_sig_i = '0;
    @(posedge clk_i); #1;
  endtask

  initial begin : stim
    rst_ni = 1'b0;
    pmu_sig_i = '0;
    req_valid_i = 1'b0;
    req_we_i = 1'b0;
    req_addr_i = '0;
    req_wdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("rst_rdata", resp_rdata_o, 64'd0);
    chk("rst_err", 64'(resp_err_o), 64'd0);
    chk("rst_irq", 64'(ovf_irq_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // cycle count
    wr(8'h00, 64'h1);
    wr(8'h01, 64'h1);
    pulse(23'h1, 100);
    rd(8'h20, 64'd100);
    rd(8'h00, 64'h1);

    // masking and freeze
    wr(8'h01, 64'h6);
    pulse(23'hE, 10);
    rd(8'h21, 64'd10);
    rd(8'h22, 64'd10);
    rd(8'h23, 64'd0);
    rd(8'h20, 64'd100);
    wr(8'h00, 64'h3);
    rd(8'h00, 64'h3);
    pulse(23'hE, 10);
    rd(8'h21, 64'd10);
    rd(8'h22, 64'd10);
    wr(8'h00, 64'h1);

    // overflow wrap and interrupt timing
    wr(8'h25, 64'hFFFF_FFFF_FFFF_FFFE);
    wr(8'h04, 64'h20);
    wr(8'h01, 64'h20);
    pulse(23'h20, 2);
    chk("irq_at_wrap", 64'(ovf_irq_o), 64'd0);
    rd(8'h02, 64'h20);
    chk("irq_rise", 64'(ovf_irq_o), 64'd1);
    rd(8'h25, 64'd0);
    rd(8'h03, 64'd0);
    wr(8'h03, 64'h20);
    rd(8'h02, 64'd0);
    chk("irq_after_clear", 64'(ovf_irq_o), 64'd0);

    // counter write beats a due increment
    wr(8'h01, 64'h10);
    pmu_sig_i = 23'h10;
    @(posedge clk_i); #1;
    pmu_sig_i = '0;
    wr(8'h24, 64'd7);
    rd(8'h24, 64'd7);

    // clear_all while events are active
    wr(8'h25, ONES);
    wr(8'h01, 64'h3F);
    pmu_sig_i = 23'h3F;
    repeat (3) @(posedge clk_i);
    #1;
    rd(8'h02, 64'h20);
    pmu_sig_i = '0;
    wr(8'h00, 64'h5);
    for (int i = 0; i < 6; i++) rd(8'(32 + i), 64'd0);
    rd(8'h02, 64'd0);
    rd(8'h00, 64'h1);
    rd(8'h01, 64'h3F);

    // new wrap beats simultaneous OVF_CLEAR
    wr(8'h25, ONES);
    pmu_sig_i = 23'h20;
    @(posedge clk_i); #1;
    pmu_sig_i = '0;
    wr(8'h03, 64'h20);
    rd(8'h02, 64'h20);
    rd(8'h25, 64'd0);

    // loading all-ones does not flag overflow
    wr(8'h03, 64'h20);
    wr(8'h01, 64'h0);
    wr(8'h25, ONES);
    rd(8'h02, 64'd0);
    rd(8'h25, ONES);

    // error path
    req(1'b0, 8'h10, 64'd0, 64'd0, 1'b1);
    req(1'b1, 8'h37, 64'hDEAD, 64'd0, 1'b1);
    req(1'b0, 8'h37, 64'd0, 64'd0, 1'b1);
    rd(8'h36, 64'd0);
    rd(8'h01, 64'd0);
    rd(8'h00, 64'h1);
    rd(8'h04, 64'h20);
    rd(8'h25, ONES);

    // asynchronous reset with a read outstanding
    req_valid_i = 1'b1;
    req_we_i = 1'b0;
    req_addr_i = 8'h25;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_resp_valid", 64'(resp_valid_o), 64'd0);
    chk("arst_rdata", resp_rdata_o, 64'd0);
    chk("arst_err", 64'(resp_err_o), 64'd0);
    chk("arst_irq", 64'(ovf_irq_o), 64'd0);
    req_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    rd(8'h25, 64'd0);
    rd(8'h00, 64'd0);
    rd(8'h01, 64'd0);
    rd(8'h04, 64'd0);

    repeat (3) @(posedge clk_i);
    tb_end = 1'b1;
    for (int k = 0; k < 20 && !mon_done; k++) @(posedge clk_i);
    if (!mon_done) begin
      $display("FAIL monitor_timeout got done=0 want done=1");
      $fatal(1, "monitor did not finish");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
